// File: rtl/bcd_updown_timer_if.sv
// rtl/bcd_updown_timer_if.sv - control and display signals of the BCD up/down timer
interface bcd_updown_timer_if #(
    parameter int DIGITS = 3
);
    logic                  enable;
    logic                  up;
    logic                  load;
    logic [4*DIGITS-1:0]   load_value;
    logic [4*DIGITS-1:0]   bcd;
    logic [7*DIGITS-1:0]   hex;
    logic                  tick;
    logic                  wrap;
    logic                  load_err;

    modport master (
        output enable, up, load, load_value,
        input  bcd, hex, tick, wrap, load_err
    );

    modport slave (
        input  enable, up, load, load_value,
        output bcd, hex, tick, wrap, load_err
    );
endinterface

// File: rtl/bcd_updown_timer.sv
// rtl/bcd_updown_timer.sv - prescaled up/down modulo counter in packed BCD with 7-seg decode
// Optional leading-zero blanking of the display: define BCD_TIMER_BLANK_EN.
module bcd_updown_timer #(
    parameter int PRESCALE = 50000000,
    parameter int DIGITS   = 3,
    parameter int MODULUS  = 1000
) (
    input  logic              clock,
    input  logic              reset,
    bcd_updown_timer_if.slave bus
);
    localparam int BW = 4 * DIGITS;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);

    function automatic logic [BW-1:0] to_bcd(input longint value);
        logic [BW-1:0] r;
        longint v;
        r = '0;
        v = value;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
    endfunction

    localparam logic [BW-1:0] TOP = to_bcd(longint'(MODULUS) - 1);

    logic [PW-1:0]   pcount;
    logic [BW-1:0]   count;
    logic [BW-1:0]   inc;
    logic [BW-1:0]   dec;
    logic            carry;
    logic            borrow;
    logic            digits_ok;
    logic            load_ok;
    logic            at_top;
    logic            at_zero;
    logic            wrap_q;
    logic            load_err_q;
    logic [7*DIGITS-1:0] hex_d;

    assign bus.tick     = bus.enable & (pcount == PLAST);
    assign bus.bcd      = count;
    assign bus.wrap     = wrap_q;
    assign bus.load_err = load_err_q;
    assign bus.hex      = hex_d;

    // Decimal carry/borrow ripple from digit 0 upward.
    always_comb begin
        inc       = count;
        dec       = count;
        carry     = 1'b1;
        borrow    = 1'b1;
        digits_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (count[4*i +: 4] == 4'd9) begin
                    inc[4*i +: 4] = 4'd0;
                end else begin
                    inc[4*i +: 4] = count[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
            if (borrow) begin
                if (count[4*i +: 4] == 4'd0) begin
                    dec[4*i +: 4] = 4'd9;
                end else begin
                    dec[4*i +: 4] = count[4*i +: 4] - 4'd1;
                    borrow = 1'b0;
                end
            end
            if (bus.load_value[4*i +: 4] > 4'd9) begin
                digits_ok = 1'b0;
            end
        end
    end

    // With all digits legal, BCD ordering matches numeric ordering.
    assign load_ok = digits_ok && (bus.load_value <= TOP);
    assign at_top  = (count == TOP);
    assign at_zero = (count == '0);

    always_ff @(posedge clock) begin
        if (!reset) begin
            pcount     <= '0;
            count      <= '0;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
            if (bus.load) begin
                if (load_ok) begin
                    count  <= bus.load_value;
                    pcount <= '0;
                end else begin
                    load_err_q <= 1'b1;
                end
            end else if (bus.tick) begin
                pcount <= '0;
                if (bus.up) begin
                    count  <= at_top ? '0 : inc;
                    wrap_q <= at_top;
                end else begin
                    count  <= at_zero ? TOP : dec;
                    wrap_q <= at_zero;
                end
            end else if (bus.enable) begin
                pcount <= pcount + PW'(1);
            end
        end
    end

`ifdef BCD_TIMER_BLANK_EN
    logic lead;

    always_comb begin
        hex_d = '0;
        lead  = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (count[4*i +: 4] != 4'd0 || i == 0) begin
                lead = 1'b0;
            end
            hex_d[7*i +: 7] = lead ? 7'h7F : seg(count[4*i +: 4]);
        end
    end
`else
    always_comb begin
        hex_d = '0;
        for (int i = 0; i < DIGITS; i++) begin
            hex_d[7*i +: 7] = seg(count[4*i +: 4]);
        end
    end
`endif
endmodule
